// File: rtl/tour_cmd_sequencer_if.sv
// RemoteComm command/response channel between the tour sequencer (master) and RemoteComm (slave).
interface tour_cmd_sequencer_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (output cmd, output snd_cmd, input cmd_snt, input resp_rdy, input resp);
    modport slave  (input cmd, input snd_cmd, output cmd_snt, output resp_rdy, output resp);
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Multi-command sequencer: issues a table of commands to RemoteComm, checks each response against
// POS_ACK and aborts on NAK or timeout. Optional SEQ_RETRY_EN adds per-command resends.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; outputs quiet
// LOAD      | register table[cmd_idx] onto cmd
// SEND      | one-cycle snd_cmd pulse, timeout counter cleared
// WAIT_SNT  | waiting for cmd_snt (a response here is still honoured)
// WAIT_RESP | waiting for resp_rdy; check against POS_ACK
// NEXT      | advance to next command or finish
// FINISH    | one-cycle done pulse
// ERR       | error latched; cmd_idx holds failing index
module tour_cmd_sequencer #(
    parameter int          DEPTH      = 8,
    parameter int          TMO_W      = 24,
    parameter int unsigned TMO_CYCLES = 32'h000F_4240,
    parameter logic [7:0]  POS_ACK    = 8'hA5,
    parameter int          MAX_RETRY  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [15:0]                wr_data_i,
    input  logic [$clog2(DEPTH):0]     num_cmds_i,
    input  logic                       start_i,
    tour_cmd_sequencer_if.master       rc,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output logic [$clog2(DEPTH)-1:0]   cmd_idx_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [1:0]       CODE_NAK = 2'b01;
    localparam logic [1:0]       CODE_TMO = 2'b10;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tour_cmd_sequencer: DEPTH must be a power of two >= 2");
    end
    if (TMO_CYCLES < 2 || 64'(TMO_CYCLES) > (64'd1 << TMO_W)) begin : g_bad_tmo
        $error("tour_cmd_sequencer: TMO_CYCLES must be >= 2 and fit in TMO_W bits");
    end
    if (MAX_RETRY < 0) begin : g_bad_retry
        $error("tour_cmd_sequencer: MAX_RETRY must be non-negative");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_SNT  = 3'd3,
        WAIT_RESP = 3'd4,
        NEXT      = 3'd5,
        FINISH    = 3'd6,
        ERR       = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              fail;
    logic [1:0]        fail_code;
    logic [CW-1:0]     num_clamped;
    logic              busy;

    logic [15:0]       cmd_tbl_q [DEPTH];

`ifdef SEQ_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX_C = RW'(MAX_RETRY);
    logic [RW-1:0]     retry_q, retry_d;
`endif

    assign busy = (state_q == LOAD) || (state_q == SEND) || (state_q == WAIT_SNT) ||
                  (state_q == WAIT_RESP) || (state_q == NEXT);

    // Requests beyond the table size run the whole table rather than spinning forever.
    assign num_clamped = (num_cmds_i > DEPTH_C) ? DEPTH_C : num_cmds_i;

    // Command table is intentionally not reset so a programmed tour survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en_i && !busy) begin
            cmd_tbl_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef SEQ_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = 2'b00;
`ifdef SEQ_RETRY_EN
        retry_d    = retry_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    idx_d      = '0;
                    cnt_d      = num_clamped;
`ifdef SEQ_RETRY_EN
                    retry_d    = '0;
`endif
                    state_d    = (num_clamped == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                cmd_d   = cmd_tbl_q[idx_q];
                state_d = SEND;
            end
            SEND: begin
                tmo_d   = '0;
                state_d = WAIT_SNT;
            end
            WAIT_SNT, WAIT_RESP: begin
                if (tmo_q != TMO_LAST) begin
                    tmo_d = tmo_q + 1'b1;
                end
                // A response on the timeout cycle takes priority over the timeout.
                if (rc.resp_rdy) begin
                    if (rc.resp == POS_ACK) begin
                        state_d = NEXT;
                    end else begin
                        fail      = 1'b1;
                        fail_code = CODE_NAK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fail      = 1'b1;
                    fail_code = CODE_TMO;
                end else if (state_q == WAIT_SNT && rc.cmd_snt) begin
                    state_d = WAIT_RESP;
                end
            end
            NEXT: begin
`ifdef SEQ_RETRY_EN
                retry_d = '0;
`endif
                if ((CW'(idx_q) + CW'(1)) == cnt_q) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
            FINISH:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fail) begin
`ifdef SEQ_RETRY_EN
            if (retry_q < RETRY_MAX_C) begin
                retry_d = retry_q + 1'b1;
                state_d = LOAD;
            end else begin
                state_d    = ERR;
                err_d      = 1'b1;
                err_code_d = fail_code;
            end
`else
            state_d    = ERR;
            err_d      = 1'b1;
            err_code_d = fail_code;
`endif
        end
    end

    assign rc.cmd     = cmd_q;
    assign rc.snd_cmd = (state_q == SEND);
    assign busy_o     = busy;
    assign done_o     = (state_q == FINISH);
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign cmd_idx_o  = idx_q;

endmodule
